// File: rtl/rsa_exp_arbiter_if.sv
// Requester-side bus of the shared mon_exp scheduler.
// master: requesters drive req/operands; slave: arbiter returns gnt/done/err/ans/busy.
interface rsa_exp_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8
);
  logic [NREQ-1:0]              req;
  logic [NREQ*BITLEN-1:0]       req_e;
  logic [NREQ*LOG_BITLEN-1:0]   req_e_idx;
  logic [NREQ*BITLEN-1:0]       req_M;
  logic [NREQ*(LOG_BITLEN+1)-1:0] req_mp_count;
  logic [NREQ-1:0]              gnt;
  logic [NREQ-1:0]              done;
  logic                         err;
  logic [BITLEN-1:0]            ans;
  logic                         busy;

  modport master (
    output req, req_e, req_e_idx, req_M, req_mp_count,
    input  gnt, done, err, ans, busy
  );

  modport slave (
    input  req, req_e, req_e_idx, req_M, req_mp_count,
    output gnt, done, err, ans, busy
  );
endinterface

// File: rtl/rsa_exp_arbiter.sv
// Round-robin scheduler sharing one mon_exp engine among NREQ requesters.
// Ports: clk, rst (async, high); bus (slave modport: req/operands in,
// gnt/done/err/ans/busy out); o_eng_* job operands and control to the
// engine; i_eng_stop/i_eng_ans completion flag and result from the engine.
module rsa_exp_arbiter #(
  parameter int NREQ       = 4,
  parameter int BITLEN     = 256,
  parameter int LOG_BITLEN = 8,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                  clk,
  input  logic                  rst,
  rsa_exp_arbiter_if.slave      bus,
  output logic                  o_eng_rst,
  output logic                  o_eng_start,
  output logic [BITLEN-1:0]     o_eng_e,
  output logic [LOG_BITLEN-1:0] o_eng_e_idx,
  output logic [BITLEN-1:0]     o_eng_M,
  output logic [LOG_BITLEN:0]   o_eng_mp_count,
  input  logic                  i_eng_stop,
  input  logic [BITLEN-1:0]     i_eng_ans
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT, S_DONE
  } state_t;

  state_t r_state, w_state_d;

  logic [IW-1:0]         r_last, w_win;
  logic                  w_any, w_ok;
  logic [BITLEN-1:0]     w_e, w_M;
  logic [LOG_BITLEN-1:0] w_idx;
  logic [LOG_BITLEN:0]   w_mp;
  logic [WDW-1:0]        r_wdog;
  logic                  r_stop_q, w_rise, w_tmo;
  logic                  r_pend, r_rej, w_done_set;
  logic [NREQ-1:0]       r_gnt, r_done;
  logic                  r_err, r_busy, r_start;
  logic [BITLEN-1:0]     r_ans, r_e, r_M;
  logic [LOG_BITLEN-1:0] r_idx;
  logic [LOG_BITLEN:0]   r_mp;

  // Walk from farthest to nearest after r_last so the nearest
  // requesting index is the one left in w_win.
  always_comb begin
    int c;
    c     = 0;
    w_any = 1'b0;
    w_win = r_last;
    for (int k = NREQ; k >= 1; k--) begin
      c = (int'(r_last) + k) % NREQ;
      if (bus.req[IW'(c)]) begin
        w_any = 1'b1;
        w_win = IW'(c);
      end
    end
  end

  always_comb begin
    w_e   = '0;
    w_M   = '0;
    w_idx = '0;
    w_mp  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_e   = bus.req_e[i*BITLEN +: BITLEN];
        w_M   = bus.req_M[i*BITLEN +: BITLEN];
        w_idx = bus.req_e_idx[i*LOG_BITLEN +: LOG_BITLEN];
        w_mp  = bus.req_mp_count[i*(LOG_BITLEN+1) +: LOG_BITLEN+1];
      end
    end
    w_ok = (w_idx != '0) && (w_mp != '0) && w_e[w_idx];
  end

  // A rejected job sits in DONE for two cycles: the first with
  // r_pend set (no pulse), the second carrying the done pulse.
  always_comb begin
    w_state_d  = r_state;
    w_done_set = 1'b0;
    w_rise     = i_eng_stop & ~r_stop_q;
    w_tmo      = (r_wdog == WDW'(TIMEOUT-1));
    unique case (r_state)
      S_IDLE:   if (w_any) w_state_d = w_ok ? S_CLEAR : S_DONE;
      S_CLEAR:  w_state_d = S_LAUNCH;
      S_LAUNCH: w_state_d = S_WAIT;
      S_WAIT: begin
        if (w_rise || w_tmo) begin
          w_state_d  = S_DONE;
          w_done_set = 1'b1;
        end
      end
      S_DONE: begin
        if (r_pend) w_done_set = 1'b1;
        else        w_state_d  = S_IDLE;
      end
      default:  w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= IW'(NREQ-1);
      r_wdog   <= '0;
      r_stop_q <= 1'b0;
      r_pend   <= 1'b0;
      r_rej    <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_ans    <= '0;
      r_e      <= '0;
      r_M      <= '0;
      r_idx    <= '0;
      r_mp     <= '0;
    end else begin
      r_state  <= w_state_d;
      r_stop_q <= (r_state == S_CLEAR) ? 1'b0 : i_eng_stop;
      r_busy   <= (w_state_d != S_IDLE);
      r_start  <= (w_state_d == S_LAUNCH);
      r_done   <= w_done_set ? r_gnt : '0;
      if (r_state == S_CLEAR)     r_wdog <= '0;
      else if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
      if (r_state == S_IDLE && w_any) begin
        r_gnt  <= NREQ'(1) << w_win;
        r_last <= w_win;
        r_e    <= w_e;
        r_M    <= w_M;
        r_idx  <= w_idx;
        r_mp   <= w_mp;
        r_rej  <= ~w_ok;
        r_pend <= ~w_ok;
        r_err  <= ~w_ok;
      end
      if (r_state == S_WAIT) begin
        if (w_rise) begin
          r_ans <= i_eng_ans;
          r_err <= 1'b0;
        end else if (w_tmo) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_DONE) begin
        r_pend <= 1'b0;
        if (!r_pend) r_gnt <= '0;
      end
    end
  end

  // A rejected job never started the engine, so it needs no reset.
  assign o_eng_rst = rst | (r_state == S_CLEAR) |
                     ((r_state == S_DONE) & r_err & ~r_rej);

  assign o_eng_start    = r_start;
  assign o_eng_e        = r_e;
  assign o_eng_e_idx    = r_idx;
  assign o_eng_M        = r_M;
  assign o_eng_mp_count = r_mp;

  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.ans  = r_ans;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_rsa_exp_arbiter.sv
// Bench for rsa_exp_arbiter: job-level reference model plus directed jobs.
// Instance A (TIMEOUT=64) is model-checked every cycle; B (TIMEOUT=16) covers timeout.
module tb_rsa_exp_arbiter;
  localparam int NR  = 4;
  localparam int BL  = 16;
  localparam int LB  = 4;
  localparam int TOA = 64;
  localparam int TOB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_exp_arbiter_if #(.NREQ(NR), .BITLEN(BL), .LOG_BITLEN(LB)) ifa ();
  rsa_exp_arbiter_if #(.NREQ(NR), .BITLEN(BL), .LOG_BITLEN(LB)) ifb ();

  logic          er_a, st_a, stop_a, er_b, st_b, stop_b;
  logic [BL-1:0] oe_a, om_a, ain_a, oe_b, om_b, ain_b;
  logic [LB-1:0] oi_a, oi_b;
  logic [LB:0]   omp_a, omp_b;

  rsa_exp_arbiter #(.NREQ(NR), .BITLEN(BL), .LOG_BITLEN(LB), .TIMEOUT(TOA)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .o_eng_rst(er_a), .o_eng_start(st_a), .o_eng_e(oe_a), .o_eng_e_idx(oi_a),
    .o_eng_M(om_a), .o_eng_mp_count(omp_a), .i_eng_stop(stop_a), .i_eng_ans(ain_a)
  );

  rsa_exp_arbiter #(.NREQ(NR), .BITLEN(BL), .LOG_BITLEN(LB), .TIMEOUT(TOB)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .o_eng_rst(er_b), .o_eng_start(st_b), .o_eng_e(oe_b), .o_eng_e_idx(oi_b),
    .o_eng_M(om_b), .o_eng_mp_count(omp_b), .i_eng_stop(stop_b), .i_eng_ans(ain_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Engine stand-ins: stop rises dly cycles after the start cycle, sticky.
  int dly_a = 0, cnt_a = 0, dly_b = 0, cnt_b = 0;
  bit run_a = 0, run_b = 0;
  initial begin
    stop_a = 1'b0; stop_b = 1'b0; ain_a = '0; ain_b = '0;
  end

  always @(posedge clk) begin : eng_a
    bit r, s;
    r = er_a; s = st_a;
    #1;
    if (r) begin run_a = 0; stop_a = 1'b0; end
    else if (s) begin run_a = 1; cnt_a = 1; end
    else if (run_a) cnt_a++;
    if (run_a && dly_a > 0 && cnt_a >= dly_a) stop_a = 1'b1;
  end

  always @(posedge clk) begin : eng_b
    bit r, s;
    r = er_b; s = st_b;
    #1;
    if (r) begin run_b = 0; stop_b = 1'b0; end
    else if (s) begin run_b = 1; cnt_b = 1; end
    else if (run_b) cnt_b++;
    if (run_b && dly_b > 0 && cnt_b >= dly_b) stop_b = 1'b1;
  end

  // Job-level model of instance A: a job occupies cycles t0+1..end.
  bit            m_act = 0, m_ok = 0, m_err = 0, m_prev = 0, fnd;
  int            m_t0, m_end, m_w, m_last = NR-1, c;
  logic [BL-1:0] m_e, m_M, m_ans = '0;
  logic [LB-1:0] m_ix;
  logic [LB:0]   m_mp;
  logic [NR-1:0] x_g, x_d, prev_g = '0;
  bit            x_s, x_r;
  int            start_cnt = 0, start_cyc = -1, rst_cnt = 0, done_cnt = 0;
  logic [NR-1:0] gq[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", ifa.gnt, 0);
      chk("rst_busy", ifa.busy, 0);
      chk("rst_start", st_a, 0);
      chk("rst_done", ifa.done, 0);
      chk("rst_ans", ifa.ans, 0);
      chk("rst_eng_rst", er_a, 1);
      m_act = 0; m_last = NR-1; m_ans = '0; m_prev = 0;
    end else begin
      x_g = m_act ? (NR'(1) << m_w) : '0;
      x_s = m_act && m_ok && (cyc == m_t0 + 2);
      x_d = (m_act && cyc == m_end) ? x_g : '0;
      x_r = m_act && m_ok && ((cyc == m_t0 + 1) || (m_err && cyc == m_end));
      chk("gnt", ifa.gnt, x_g);
      chk("busy", ifa.busy, m_act);
      chk("eng_start", st_a, x_s);
      chk("done", ifa.done, x_d);
      chk("eng_rst", er_a, x_r);
      chk("ans", ifa.ans, m_ans);
      if (x_d != '0) chk("err", ifa.err, m_err);
      if (m_act) begin
        chk("eng_e", oe_a, m_e);
        chk("eng_M", om_a, m_M);
        chk("eng_e_idx", oi_a, m_ix);
        chk("eng_mp", omp_a, m_mp);
      end
      if (m_act && cyc == m_end) begin
        m_act = 0;
      end else if (m_act && m_ok && m_end < 0 && cyc >= m_t0 + 3) begin
        if (stop_a && !m_prev) begin
          m_end = cyc + 1; m_err = 0; m_ans = ain_a;
        end else if (cyc == m_t0 + 2 + TOA) begin
          m_end = cyc + 1; m_err = 1;
        end
      end else if (!m_act && ifa.req != '0) begin
        fnd = 0;
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (!fnd && ifa.req[c]) begin fnd = 1; m_w = c; end
        end
        m_last = m_w;
        m_e  = ifa.req_e[m_w*BL +: BL];
        m_M  = ifa.req_M[m_w*BL +: BL];
        m_ix = ifa.req_e_idx[m_w*LB +: LB];
        m_mp = ifa.req_mp_count[m_w*(LB+1) +: LB+1];
        m_ok = (m_ix != 0) && (m_mp != 0) && m_e[m_ix];
        m_act = 1; m_t0 = cyc; m_err = !m_ok;
        m_end = m_ok ? -1 : cyc + 2;
      end
      m_prev = stop_a;
    end
    if (st_a) begin start_cnt++; start_cyc = cyc; end
    if (er_a) rst_cnt++;
    if (ifa.done != '0) done_cnt++;
    if (ifa.gnt != '0 && prev_g == '0) gq.push_back(ifa.gnt);
    prev_g = ifa.gnt;
  end

  task automatic set_a(input int i, input logic [BL-1:0] e, input logic [LB-1:0] ix,
                       input logic [BL-1:0] m, input logic [LB:0] mp);
    ifa.req_e[i*BL +: BL] = e;
    ifa.req_e_idx[i*LB +: LB] = ix;
    ifa.req_M[i*BL +: BL] = m;
    ifa.req_mp_count[i*(LB+1) +: LB+1] = mp;
  endtask

  task automatic set_b(input int i, input logic [BL-1:0] e, input logic [LB-1:0] ix,
                       input logic [BL-1:0] m, input logic [LB:0] mp);
    ifb.req_e[i*BL +: BL] = e;
    ifb.req_e_idx[i*LB +: LB] = ix;
    ifb.req_M[i*BL +: BL] = m;
    ifb.req_mp_count[i*(LB+1) +: LB+1] = mp;
  endtask

  task automatic wait_done(input bit on_b, input int i, input int lim, output int dc);
    dc = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (on_b ? ifb.done[i] : ifa.done[i]) begin dc = cyc; break; end
    end
    if (dc < 0) begin
      n_chk++; n_err++;
      $display("FAIL wait_done: requester %0d never completed within %0d cycles", i, lim);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  int t0, dc, seq[5];

  initial begin
    ifa.req = '0; ifa.req_e = '0; ifa.req_e_idx = '0; ifa.req_M = '0; ifa.req_mp_count = '0;
    ifb.req = '0; ifb.req_e = '0; ifb.req_e_idx = '0; ifb.req_M = '0; ifb.req_mp_count = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single job on requester 2, engine answers 40 cycles after start.
    set_a(2, 16'b1011, 4'd3, 16'h00F1, 5'd9);
    dly_a = 40; ain_a = 16'h005A; start_cnt = 0;
    ifa.req = 4'b0100; t0 = cyc;
    wait_done(0, 2, 100, dc);
    chk("single_start_cycle", start_cyc - t0, 2);
    chk("single_done_cycle", dc - t0, 43);
    chk("single_ans", ifa.ans, 16'h005A);
    chk("single_err", ifa.err, 0);
    step(); ifa.req = '0; step();

    // Rejections: e_idx==0, then e[e_idx]==0.
    set_a(1, 16'h00FF, 4'd0, 16'h0011, 5'd5);
    start_cnt = 0; rst_cnt = 0;
    ifa.req = 4'b0010; t0 = cyc;
    wait_done(0, 1, 20, dc);
    chk("rej_done_cycle", dc - t0, 2);
    chk("rej_err", ifa.err, 1);
    step(); ifa.req = '0; step();
    chk("rej_no_start", start_cnt, 0);
    chk("rej_no_eng_rst", rst_cnt, 0);
    set_a(0, 16'b1011, 4'd2, 16'h0011, 5'd5);
    ifa.req = 4'b0001; t0 = cyc;
    wait_done(0, 0, 20, dc);
    chk("rej2_done_cycle", dc - t0, 2);
    chk("rej2_err", ifa.err, 1);
    step(); ifa.req = '0; step();

    // Stop rising edge on the same cycle the watchdog expires.
    set_a(3, 16'h8001, 4'd15, 16'hFFF1, 5'd16);
    dly_a = TOA; ain_a = 16'h00C3;
    ifa.req = 4'b1000; t0 = cyc;
    wait_done(0, 3, 200, dc);
    chk("coll_done_cycle", dc - t0, TOA + 3);
    chk("coll_err", ifa.err, 0);
    chk("coll_ans", ifa.ans, 16'h00C3);
    step(); ifa.req = '0; step();

    // Reset while the job is in WAIT.
    set_a(1, 16'h0006, 4'd2, 16'h0035, 5'd3);
    dly_a = 40; ain_a = 16'h0099; done_cnt = 0;
    ifa.req = 4'b0010;
    repeat (8) step();
    chk("mid_busy_before", ifa.busy, 1);
    rst = 1'b1; ifa.req = '0;
    #1;
    chk("mid_gnt", ifa.gnt, 0);
    chk("mid_busy", ifa.busy, 0);
    chk("mid_start", st_a, 0);
    chk("mid_eng_rst", er_a, 1);
    step(); step();
    rst = 1'b0;
    repeat (50) step();
    chk("mid_no_done", done_cnt, 0);

    // Fairness: all four requesting continuously.
    set_a(0, 16'h0003, 4'd1, 16'h0007, 5'd2);
    set_a(1, 16'h0005, 4'd2, 16'h000B, 5'd3);
    set_a(2, 16'h0009, 4'd3, 16'h000D, 5'd4);
    set_a(3, 16'h0011, 4'd4, 16'h0013, 5'd5);
    dly_a = 5; ain_a = 16'h1234;
    gq.delete(); start_cnt = 0;
    ifa.req = 4'b1111;
    for (int n = 0; n < 300 && gq.size() < 5; n++) step();
    ifa.req = '0;
    for (int n = 0; n < 50 && (ifa.busy || m_act); n++) step();
    step();
    seq = '{0, 1, 2, 3, 0};
    chk("fair_grants", gq.size(), 5);
    for (int j = 0; j < 5 && j < gq.size(); j++)
      chk($sformatf("fair_grant%0d", j), gq[j], NR'(1) << seq[j]);
    chk("fair_starts", start_cnt, gq.size());

    // Timeout on instance B after a completed job leaves ans=0x77.
    set_b(0, 16'h0003, 4'd1, 16'h0007, 5'd2);
    dly_b = 5; ain_b = 16'h0077;
    ifb.req = 4'b0001; t0 = cyc;
    wait_done(1, 0, 40, dc);
    chk("tob_first_done", dc - t0, 8);
    chk("tob_first_ans", ifb.ans, 16'h0077);
    step(); ifb.req = '0; step();
    set_b(1, 16'h000C, 4'd3, 16'h001D, 5'd6);
    dly_b = 0; ain_b = 16'h00EE;
    ifb.req = 4'b0010; t0 = cyc;
    wait_done(1, 1, 60, dc);
    chk("to_done_cycle", dc - t0, TOB + 3);
    chk("to_err", ifb.err, 1);
    chk("to_eng_rst", er_b, 1);
    chk("to_ans_kept", ifb.ans, 16'h0077);
    step(); ifb.req = '0; step();
    chk("to_idle_busy", ifb.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

endmodule
